img_uart_streamer: RTL and testbench

Successor to the fixed-size image sender. It reads NUM_PIXELS 24-bit RGB pixels from a synchronous-read image RAM, starting at BASE_ADDR. Each pixel is converted per a run-time mode (single gray byte, triple gray byte, or raw R,G,B), and the resulting bytes are pushed into the UART TX FIFO with a real tx_full handshake. Sits between the image RAM and the uart block's wr_uart/w_data/tx_full interface. Supports one-shot and continuous (loop) operation.

---
 rtl/img_uart_streamer.sv | 159 +++++++++++++++
 tb/tb_img_uart_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_uart_streamer.sv
// img_uart_streamer: walks NUM_PIXELS 24-bit RGB pixels in a synchronous-read
// image RAM and streams them as bytes into the UART TX FIFO. Each pixel is sent
// as one gray byte, three gray bytes or raw R,G,B, depending on the latched mode.
// The FIFO handshake is wr_uart = !tx_full while sending.
module img_uart_streamer #(
    parameter int ADDR_BITS  = 13,
    parameter int NUM_PIXELS = 6867,
    parameter int BASE_ADDR  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 loop,
    input  logic [1:0]           mode,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [23:0]          mem_do,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] pixel_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_BITS-1:0] BASE_A   = ADDR_BITS'(BASE_ADDR);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_PIXELS - 1);

    // Luma approximation; the weights sum to 256, so the 16-bit sum cannot overflow.
    function automatic logic [7:0] gray_of(input logic [23:0] pix);
        logic [15:0] acc;
        acc = 16'd77  * {8'd0, pix[23:16]}
            + 16'd150 * {8'd0, pix[15:8]}
            + 16'd29  * {8'd0, pix[7:0]};
        return acc[15:8];
    endfunction

    // Byte to present for a given mode and byte position within the pixel.
    function automatic logic [7:0] byte_sel(input logic [1:0]  m,
                                            input logic [23:0] pix,
                                            input logic [1:0]  cnt);
        logic [7:0] b;
        if (m == 2'd2) begin
            case (cnt)
                2'd0:    b = pix[23:16];
                2'd1:    b = pix[15:8];
                default: b = pix[7:0];
            endcase
        end else begin
            b = gray_of(pix);
        end
        return b;
    endfunction

    state_t                 r_state, w_state_next;
    logic [ADDR_BITS-1:0]   r_pixel_idx, w_pixel_idx_next;
    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic [1:0]             r_mode, w_mode_next;
    logic [23:0]            r_pixel, w_pixel_next;
    logic [1:0]             r_byte_cnt, w_byte_cnt_next;
    logic                   w_wr;
    logic                   w_last_byte;

    // Modes 1 and 2 send three bytes per pixel; modes 0 and 3 send one.
    assign w_last_byte = ((r_mode == 2'd1) || (r_mode == 2'd2)) ? (r_byte_cnt == 2'd2) : 1'b1;

    // State register and datapath registers; the address is precomputed so it is valid throughout FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pixel_idx <= '0;
            r_mem_addr  <= BASE_A;
            r_mode      <= 2'd0;
            r_pixel     <= 24'd0;
            r_byte_cnt  <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_pixel_idx <= w_pixel_idx_next;
            r_mem_addr  <= BASE_A + w_pixel_idx_next;
            r_mode      <= w_mode_next;
            r_pixel     <= w_pixel_next;
            r_byte_cnt  <= w_byte_cnt_next;
        end
    end

    // Next-state logic and the FIFO write strobe.
    always_comb begin
        w_state_next     = r_state;
        w_pixel_idx_next = r_pixel_idx;
        w_mode_next      = r_mode;
        w_pixel_next     = r_pixel;
        w_byte_cnt_next  = r_byte_cnt;
        w_wr             = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pixel_idx_next = '0;
                if (start) begin
                    w_mode_next  = mode;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_pixel_next    = mem_do;
                w_byte_cnt_next = 2'd0;
                w_state_next    = S_SEND;
            end
            S_SEND: begin
                if (!tx_full) begin
                    w_wr = 1'b1;
                    if (w_last_byte) begin
                        if (r_pixel_idx == LAST_IDX) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_pixel_idx_next = r_pixel_idx + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                            w_state_next     = S_FETCH;
                        end
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 2'd1;
                    end
                end else begin
                    w_state_next = S_SEND;
                end
            end
            S_DONE: begin
                w_pixel_idx_next = '0;
                if (loop) begin
                    w_mode_next  = mode;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_pixel_idx_next = '0;
            end
        endcase
    end

    assign mem_addr  = r_mem_addr;
    assign pixel_idx = r_pixel_idx;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign wr_uart   = w_wr;
    assign w_data    = byte_sel(r_mode, r_pixel, r_byte_cnt);

endmodule

// File: tb/tb_img_uart_streamer.sv
// Directed bench for img_uart_streamer: unit A (4 pixels at address 0) covers
// modes, stalls, looping and reset; unit C (4 pixels at 8190) covers address wrap.
module tb_img_uart_streamer;

    localparam int AB = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          a_start = 1'b0;
    logic          c_start = 1'b0;
    logic          loop_i = 1'b0;
    logic          tx_full = 1'b0;
    logic [1:0]    mode = 2'd0;

    logic [AB-1:0] a_mem_addr, a_pixel_idx, c_mem_addr, c_pixel_idx;
    logic [23:0]   a_mem_do, c_mem_do;
    logic          a_wr, a_busy, a_done, c_wr, c_busy, c_done;
    logic [7:0]    a_w_data, c_w_data;

    logic [23:0]   ram [0:(1<<AB)-1];

    img_uart_streamer #(.ADDR_BITS(AB), .NUM_PIXELS(4), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .loop(loop_i), .mode(mode),
        .mem_addr(a_mem_addr), .mem_do(a_mem_do), .tx_full(tx_full),
        .wr_uart(a_wr), .w_data(a_w_data), .busy(a_busy), .done(a_done),
        .pixel_idx(a_pixel_idx)
    );

    img_uart_streamer #(.ADDR_BITS(AB), .NUM_PIXELS(4), .BASE_ADDR(8190)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .loop(1'b0), .mode(mode),
        .mem_addr(c_mem_addr), .mem_do(c_mem_do), .tx_full(1'b0),
        .wr_uart(c_wr), .w_data(c_w_data), .busy(c_busy), .done(c_done),
        .pixel_idx(c_pixel_idx)
    );

    // Synchronous-read RAM models, one read port per unit.
    always @(posedge clk) begin
        a_mem_do <= ram[a_mem_addr];
        c_mem_do <= ram[c_mem_addr];
    end

    int cyc = 0;
    // Edge counter used to time strobes relative to the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    a_bytes[$];
    int            a_cycs[$];
    int            a_done_cycs[$];
    logic          post_busy_q[$];
    logic [AB-1:0] post_addr_q[$];
    logic [AB-1:0] post_idx_q[$];
    int            a_done_cnt = 0;
    logic          a_prev_done = 1'b0;
    bit            watch_busy = 1'b0;
    int            busy_drops = 0;
    logic [7:0]    c_bytes[$];
    logic [AB-1:0] c_addrs[$];
    int            c_done_cnt = 0;

    // Monitor on the falling edge: log accepted bytes, done pulses and the cycle after each done.
    always @(negedge clk) begin
        if (a_wr) begin
            a_bytes.push_back(a_w_data);
            a_cycs.push_back(cyc);
        end
        if (a_prev_done) begin
            post_busy_q.push_back(a_busy);
            post_addr_q.push_back(a_mem_addr);
            post_idx_q.push_back(a_pixel_idx);
        end
        a_prev_done <= a_done;
        if (a_done) begin
            a_done_cnt <= a_done_cnt + 1;
            a_done_cycs.push_back(cyc);
        end
        if (watch_busy && !a_busy) busy_drops <= busy_drops + 1;
        if (c_wr) begin
            c_bytes.push_back(c_w_data);
            c_addrs.push_back(c_mem_addr);
        end
        if (c_done) c_done_cnt <= c_done_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; c0 is the edge count just after the start edge.
    task automatic pulse_start_a(input logic [1:0] m, output int c0);
        mode    = m;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        c0      = cyc;
        a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (a_done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, a_done_cnt, target);
    endtask

    // Pixel 2 is pure red: 77*0xFF = 19635, >>8 = 76 = 0x4C.
    logic [7:0] exp_m0 [4]  = '{8'hFF, 8'h00, 8'h4C, 8'h95};
    logic [7:0] exp_m1 [12] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                                8'h4C, 8'h4C, 8'h4C, 8'h95, 8'h95, 8'h95};
    logic [7:0] exp_m2 [12] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                                8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    logic [7:0] exp_c  [4]  = '{8'h1C, 8'h4C, 8'hFF, 8'h00};
    int         exp_ca [4]  = '{8190, 8191, 0, 1};

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c0, bb, db, n;
        for (int i = 0; i < (1 << AB); i++) ram[i] = 24'h000000;
        ram[0]    = 24'hFFFFFF;
        ram[1]    = 24'h000000;
        ram[2]    = 24'hFF0000;
        ram[3]    = 24'h00FF00;
        ram[8190] = 24'h0000FF;
        ram[8191] = 24'hFF0000;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_val("rst_wr", a_wr, 0);
        check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_addr", a_mem_addr, 0);
        check_val("rst_idx", a_pixel_idx, 0);
        check_val("rst_wdata", a_w_data, 0);
        check_val("rst_addr_c", c_mem_addr, 8190);
        tick();
        reset = 1'b0;
        tick();

        // Mode 0: one gray byte per pixel, timing of strobes and done
        bb = a_bytes.size();
        db = a_done_cnt;
        pulse_start_a(2'd0, c0);
        wait_a_done(db + 1, 60, "m0_done");
        check_val("m0_busy_after", a_busy, 0);
        check_val("m0_addr_after", a_mem_addr, 0);
        check_val("m0_count", a_bytes.size() - bb, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("m0_byte%0d", i), a_bytes[bb+i], exp_m0[i]);
        check_val("m0_first_lat", a_cycs[bb] - c0, 2);
        for (int i = 1; i < 4; i++) check_val($sformatf("m0_gap%0d", i), a_cycs[bb+i] - a_cycs[bb+i-1], 3);
        check_val("m0_done_lat", a_done_cycs[db] - a_cycs[bb+3], 1);
        repeat (3) tick();
        check_val("m0_single_done", a_done_cnt - db, 1);

        // Mode 2: raw R,G,B
        bb = a_bytes.size();
        db = a_done_cnt;
        pulse_start_a(2'd2, c0);
        mode = 2'd1;
        wait_a_done(db + 1, 80, "m2_done");
        check_val("m2_count", a_bytes.size() - bb, 12);
        for (int i = 0; i < 12; i++) check_val($sformatf("m2_byte%0d", i), a_bytes[bb+i], exp_m2[i]);
        check_val("m2_pix_gap", a_cycs[bb+3] - a_cycs[bb+2], 3);
        tick();

        // Mode 1: gray repeated three times
        bb = a_bytes.size();
        db = a_done_cnt;
        pulse_start_a(2'd1, c0);
        wait_a_done(db + 1, 80, "m1_done");
        check_val("m1_count", a_bytes.size() - bb, 12);
        for (int i = 0; i < 12; i++) check_val($sformatf("m1_byte%0d", i), a_bytes[bb+i], exp_m1[i]);
        tick();

        // Mode 3 behaves like mode 0
        bb = a_bytes.size();
        db = a_done_cnt;
        pulse_start_a(2'd3, c0);
        wait_a_done(db + 1, 60, "m3_done");
        check_val("m3_count", a_bytes.size() - bb, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("m3_byte%0d", i), a_bytes[bb+i], exp_m0[i]);
        tick();

        // FIFO full for 5 SEND cycles on pixel 0
        bb = a_bytes.size();
        db = a_done_cnt;
        tx_full = 1'b1;
        pulse_start_a(2'd0, c0);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val($sformatf("stall_wr%0d", k), a_wr, 0);
            check_val($sformatf("stall_wdata%0d", k), a_w_data, 8'hFF);
        end
        @(posedge clk);
        #1;
        tx_full = 1'b0;
        wait_a_done(db + 1, 60, "stall_done");
        check_val("stall_count", a_bytes.size() - bb, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("stall_byte%0d", i), a_bytes[bb+i], exp_m0[i]);
        check_val("stall_first_cyc", a_cycs[bb] - c0, 7);
        tick();

        // Loop: frames follow back to back, busy never drops
        bb = a_bytes.size();
        db = a_done_cnt;
        loop_i = 1'b1;
        pulse_start_a(2'd0, c0);
        watch_busy = 1'b1;
        wait_a_done(db + 2, 100, "loop_done2");
        watch_busy = 1'b0;
        loop_i = 1'b0;
        wait_a_done(db + 3, 100, "loop_done3");
        tick();
        check_val("loop_busy_drops", busy_drops, 0);
        check_val("loop_count", a_bytes.size() - bb, 12);
        for (int i = 0; i < 12; i++) check_val($sformatf("loop_byte%0d", i), a_bytes[bb+i], exp_m0[i%4]);
        for (int f = 0; f < 2; f++) begin
            check_val($sformatf("loop_post_busy%0d", f), post_busy_q[db+f], 1);
            check_val($sformatf("loop_post_addr%0d", f), post_addr_q[db+f], 0);
            check_val($sformatf("loop_post_idx%0d", f), post_idx_q[db+f], 0);
        end
        check_val("loop_restart_lat", a_cycs[bb+4] - a_done_cycs[db], 3);
        check_val("loop_end_busy", post_busy_q[db+2], 0);

        // Address wrap on unit C
        bb = c_bytes.size();
        n  = c_done_cnt;
        mode = 2'd0;
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int k = 0; k < 60 && c_done_cnt == n; k++) @(negedge clk);
        check_val("wrap_done", c_done_cnt - n, 1);
        check_val("wrap_count", c_bytes.size() - bb, 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("wrap_addr%0d", i), c_addrs[bb+i], exp_ca[i]);
            check_val($sformatf("wrap_byte%0d", i), c_bytes[bb+i], exp_c[i]);
        end
        tick();

        // Reset during a stalled SEND of pixel 2, start held high while busy
        bb = a_bytes.size();
        db = a_done_cnt;
        mode = 2'd0;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        repeat (7) @(posedge clk);
        #1;
        tx_full = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rs_send_wr", a_wr, 0);
        check_val("rs_send_idx", a_pixel_idx, 2);
        check_val("rs_send_wdata", a_w_data, 8'h4C);
        check_val("rs_send_busy", a_busy, 1);
        check_val("rs_bytes_before", a_bytes.size() - bb, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("rs_wr", a_wr, 0);
        check_val("rs_busy", a_busy, 0);
        check_val("rs_addr", a_mem_addr, 0);
        check_val("rs_idx", a_pixel_idx, 0);
        check_val("rs_done", a_done, 0);
        check_val("rs_wdata", a_w_data, 0);
        tick();
        tx_full = 1'b0;
        reset = 1'b0;
        repeat (6) tick();
        check_val("rs_no_more_bytes", a_bytes.size() - bb, 2);
        check_val("rs_no_done", a_done_cnt - db, 0);
        check_val("rs_idle", a_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
